vend_sequencer: RTL
===================

Name: vend_sequencer

Overview:
Transaction controller for a multi-product vending unit. It accumulates coin credit, latches a product selection against a programmable price table, and sequences the dispense motor through a req/done handshake. It then pays out change one unit at a time through a coin-hopper req/ack handshake. Credit is counted in units of 50: coin100 = 2 units, coin150 = 3 units.

Parameters:
CREDIT_W, 5, width of credit counter and price entries (max credit 2^CREDIT_W-1 units)
N_PROD, 4, number of products (selection index width = clog2(N_PROD))
PRICE_DEFAULT, 3, reset value of every price entry (units)
IDLE_TIMEOUT, 1000, cycles with credit>0 and no coin/select before automatic refund
VEND_TIMEOUT, 255, max cycles waiting for vend_done before fault

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
coin100  in  1  single-cycle pulse, 100 coin inserted (+2 units)
coin150  in  1  single-cycle pulse, 150 coin inserted (+3 units)
sel_valid  in  1  single-cycle pulse, product selection
sel_id  in  clog2(N_PROD)  selected product index
cancel  in  1  single-cycle pulse, refund request
price_we  in  1  price table write enable
price_addr  in  clog2(N_PROD)  price entry index
price_wdata  in  CREDIT_W  new price (units); 0 = product disabled
vend_req  out  1  dispense motor request, held until vend_done
vend_id  out  clog2(N_PROD)  product being dispensed, stable while vend_req=1
vend_done  in  1  motor completion pulse
pay_req  out  1  hopper request for one 50-unit coin
pay_ack  in  1  hopper paid one coin
credit  out  CREDIT_W  current credit (registered)
busy  out  1  1 in any state except COLLECT
coin_reject  out  1  one-cycle pulse, coin returned mechanically (not credited)
fault  out  1  sticky, set on vend timeout

Behaviour:
- Reset (async): state=COLLECT, credit=0, all prices=PRICE_DEFAULT, vend_req=0, pay_req=0, coin_reject=0, fault=0, timers=0. Reset mid-transaction aborts everything; no payout of lost credit.
- All outputs are registered; each reaction appears the cycle after the triggering input.
- States: COLLECT, VEND, PAYOUT, FAULT.
- COLLECT:
  - A coin adds its units to credit.
  - coin100 and coin150 in the same cycle: both rejected (coin_reject=1), credit unchanged.
  - Coin that would exceed 2^CREDIT_W-1: rejected.
  - sel_valid with price[sel_id]!=0 and credit>=price: latch vend_id=sel_id and the price, assert vend_req, go to VEND.
  - sel_valid with insufficient credit or disabled product: ignored.
  - Coin and sel_valid in the same cycle: the coin is credited first; selection is evaluated against the pre-coin credit.
  - cancel with credit>0: go to PAYOUT. cancel with credit=0: ignored. cancel has priority over sel_valid.
  - Idle timer counts while credit>0 and no coin/sel_valid/cancel; it clears on any of those. At IDLE_TIMEOUT it behaves as cancel.
- VEND:
  - Coins rejected; sel_valid and cancel ignored.
  - On vend_done: vend_req=0, credit -= latched price. Go to PAYOUT if the result is >0, else COLLECT.
  - Vend timer reaches VEND_TIMEOUT without vend_done: vend_req=0, fault=1, go to PAYOUT with credit unchanged (full refund), then FAULT.
- PAYOUT:
  - pay_req=1 while credit>0; coins rejected; sel_valid and cancel ignored.
  - Each cycle with pay_req=1 and pay_ack=1 decrements credit by 1.
  - When credit reaches 0: pay_req=0 in that same registered update. Go to COLLECT, or FAULT if fault=1.
  - pay_ack while pay_req=0 is ignored.
- FAULT: coins rejected, selections ignored, vend_req=pay_req=0. Exit only by reset.
- Price writes are accepted in any state and take effect the next cycle. A transaction in VEND uses its latched price.
- vend_done outside VEND is ignored.

Test Plan:
1. Reset; coin150, sel_valid id=0 (price 3) -> vend_req=1 vend_id=0; vend_done -> credit=0, back to COLLECT, no pay_req.
2. coin100, coin150 (credit 5), sel id=1 price 3, vend_done -> PAYOUT; two pay_ack pulses -> credit 2 to 1 to 0, pay_req drops, COLLECT.
3. coin100 and coin150 in the same cycle -> coin_reject=1, credit stays 0. With credit=30 (CREDIT_W=5), coin100 -> rejected.
4. price_we addr=2 data=0, then coin150+coin150 and sel id=2 -> ignored. sel id=2 with credit 2, price 3 -> ignored, credit kept.
5. coin100, then no activity for IDLE_TIMEOUT cycles -> pay_req=1, two acks -> credit=0. Also: cancel during VEND -> ignored.
6. coin150, sel id=0, withhold vend_done VEND_TIMEOUT cycles -> fault=1, three acks refund credit 3 to 0 -> FAULT; further coins -> coin_reject; reset clears fault.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, price-table selection,
// dispense motor handshake and one-unit-at-a-time change payout.
module vend_sequencer #(
    parameter int unsigned CREDIT_W      = 5,
    parameter int unsigned N_PROD        = 4,
    parameter int unsigned PRICE_DEFAULT = 3,
    parameter int unsigned IDLE_TIMEOUT  = 1000,
    parameter int unsigned VEND_TIMEOUT  = 255,
    localparam int unsigned SEL_W        = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                coin100,
    input  logic                coin150,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    input  logic                cancel,
    input  logic                price_we,
    input  logic [SEL_W-1:0]    price_addr,
    input  logic [CREDIT_W-1:0] price_wdata,
    output logic                vend_req,
    output logic [SEL_W-1:0]    vend_id,
    input  logic                vend_done,
    output logic                pay_req,
    input  logic                pay_ack,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                fault
);

    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
    localparam int unsigned VEND_W = $clog2(VEND_TIMEOUT + 1);

    typedef enum logic [1:0] {COLLECT, VEND, PAYOUT, FAULT} state_t;

    state_t              state, state_n;
    logic [CREDIT_W-1:0] price [N_PROD];
    logic [CREDIT_W-1:0] credit_n, vend_price, vend_price_n, sel_price;
    logic [SEL_W-1:0]    vend_id_n;
    logic                vend_req_n, pay_req_n, coin_reject_n, fault_n, busy_n;
    logic [IDLE_W-1:0]   idle_cnt, idle_n;
    logic [VEND_W-1:0]   vend_cnt, vend_n;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_any, coin_both, idle_fire;

    // Extra top bit of coin_sum flags a coin that would overflow the credit counter
    assign coin_any  = coin100 | coin150;
    assign coin_both = coin100 & coin150;
    assign coin_sum  = {1'b0, credit} + (coin150 ? (CREDIT_W+1)'(3) : (CREDIT_W+1)'(2));
    assign sel_price = price[sel_id];

    // Price table, writable in any state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(N_PROD); i++) begin
                price[i] <= CREDIT_W'(PRICE_DEFAULT);
            end
        end else if (price_we) begin
            price[price_addr] <= price_wdata;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= COLLECT;
            credit      <= '0;
            vend_req    <= 1'b0;
            vend_id     <= '0;
            vend_price  <= '0;
            pay_req     <= 1'b0;
            busy        <= 1'b0;
            coin_reject <= 1'b0;
            fault       <= 1'b0;
            idle_cnt    <= '0;
            vend_cnt    <= '0;
        end else begin
            state       <= state_n;
            credit      <= credit_n;
            vend_req    <= vend_req_n;
            vend_id     <= vend_id_n;
            vend_price  <= vend_price_n;
            pay_req     <= pay_req_n;
            busy        <= busy_n;
            coin_reject <= coin_reject_n;
            fault       <= fault_n;
            idle_cnt    <= idle_n;
            vend_cnt    <= vend_n;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_n       = state;
        credit_n      = credit;
        vend_req_n    = vend_req;
        vend_id_n     = vend_id;
        vend_price_n  = vend_price;
        pay_req_n     = pay_req;
        coin_reject_n = 1'b0;
        fault_n       = fault;
        idle_n        = '0;
        vend_n        = '0;
        idle_fire     = 1'b0;

        case (state)
            COLLECT: begin
                if (coin_any) begin
                    if (coin_both || coin_sum[CREDIT_W]) begin
                        coin_reject_n = 1'b1;
                    end else begin
                        credit_n = coin_sum[CREDIT_W-1:0];
                    end
                end
                if (!(coin_any || sel_valid || cancel) && credit != '0) begin
                    if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
                        idle_fire = 1'b1;
                    end else begin
                        idle_n = idle_cnt + IDLE_W'(1);
                    end
                end
                // Selection is judged against the credit held before any coin this cycle
                if ((cancel || idle_fire) && credit != '0) begin
                    state_n   = PAYOUT;
                    pay_req_n = 1'b1;
                end else if (sel_valid && sel_price != '0 && credit >= sel_price) begin
                    state_n      = VEND;
                    vend_req_n   = 1'b1;
                    vend_id_n    = sel_id;
                    vend_price_n = sel_price;
                end
            end

            VEND: begin
                coin_reject_n = coin_any;
                if (vend_done) begin
                    vend_req_n = 1'b0;
                    credit_n   = credit - vend_price;
                    if (credit_n != '0) begin
                        state_n   = PAYOUT;
                        pay_req_n = 1'b1;
                    end else begin
                        state_n = COLLECT;
                    end
                end else if (vend_cnt == VEND_W'(VEND_TIMEOUT - 1)) begin
                    // Motor never finished: refund everything, then lock up
                    vend_req_n = 1'b0;
                    fault_n    = 1'b1;
                    state_n    = PAYOUT;
                    pay_req_n  = (credit != '0);
                end else begin
                    vend_n = vend_cnt + VEND_W'(1);
                end
            end

            PAYOUT: begin
                coin_reject_n = coin_any;
                if (credit == '0) begin
                    pay_req_n = 1'b0;
                    state_n   = fault ? FAULT : COLLECT;
                end else if (pay_req && pay_ack) begin
                    credit_n = credit - CREDIT_W'(1);
                    if (credit_n == '0) begin
                        pay_req_n = 1'b0;
                        state_n   = fault ? FAULT : COLLECT;
                    end
                end
            end

            FAULT: begin
                coin_reject_n = coin_any;
                vend_req_n    = 1'b0;
                pay_req_n     = 1'b0;
            end

            default: state_n = COLLECT;
        endcase

        busy_n = (state_n != COLLECT);
    end

endmodule
